// File: rtl/perceptron_pkg.sv
// Shared constants, state encoding and saturating weight arithmetic for the perceptron trainer.
// Build option: define BIAS_EN to add a per-neuron bias term.
package perceptron_pkg;

   localparam int N_NEURON = 8;
   localparam int N_IN     = 8;

`ifdef BIAS_EN
   // Nine terms per sum need one extra guard bit.
   localparam int ACC_GUARD = 4;
   localparam int N_STEP    = 9;
`else
   localparam int ACC_GUARD = 3;
   localparam int N_STEP    = 8;
`endif

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SUM    = 3'd1;
   localparam state_t ST_DECIDE = 3'd2;
   localparam state_t ST_UPDATE = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   function automatic logic [31:0] sat_add(input logic [31:0] w, input logic [31:0] step,
                                           input logic [31:0] max_v);
      logic [32:0] s;
      s = {1'b0, w} + {1'b0, step};
      return (s > {1'b0, max_v}) ? max_v : s[31:0];
   endfunction

   function automatic logic [31:0] sat_sub(input logic [31:0] w, input logic [31:0] step);
      return (step > w) ? 32'd0 : (w - step);
   endfunction

endpackage

// File: rtl/perceptron_trainer_weight_bank.sv
// 8x8 weight storage: one registered write port, a datapath read port and an external read port.
module weight_bank
   import perceptron_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [2:0]       wr_neuron,
   input  logic [2:0]       wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [5:0]       dp_sel,
   output logic [WIDTH-1:0] dp_data,
   input  logic [5:0]       rd_sel,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [N_NEURON*N_IN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_NEURON*N_IN; k++) mem[k] <= '0;
      end else if (we) begin
         mem[{wr_neuron, wr_idx}] <= wr_data;
      end
   end

   assign dp_data = mem[dp_sel];
   assign rd_data = mem[rd_sel];

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron-rule trainer: walks one neuron at a time, one weight per cycle, with saturating weights.
// Build option: BIAS_EN adds a bias register per neuron trained as a constant-1 input.
module perceptron_trainer
   import perceptron_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int THRESH = 2,
   parameter int LR     = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             train_valid,
   output logic             train_ready,
   input  logic [7:0]       x_in,
   input  logic [7:0]       target_in,
   output logic             busy,
   output logic             done,
   output logic [7:0]       pred,
   output logic [3:0]       err_cnt,
`ifdef BIAS_EN
   input  logic [2:0]       rd_bias_sel,
   output logic [WIDTH-1:0] rd_bias,
`endif
   input  logic [5:0]       rd_sel,
   output logic [WIDTH-1:0] rd_data
);

   localparam int          ACC_W    = WIDTH + ACC_GUARD;
   localparam logic [3:0]  LAST_IDX = 4'(N_STEP - 1);
   localparam logic [31:0] W_MAX    = 32'((64'd1 << WIDTH) - 64'd1);

   state_t           state;
   logic [2:0]       n;
   logic [3:0]       idx;
   logic [ACC_W-1:0] acc;
   logic [7:0]       x_r;
   logic [7:0]       t_r;
   logic [WIDTH-1:0] w_arr;
   logic [WIDTH-1:0] w_cur;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] term;
   logic             is_bias;
   logic             in_bit;
   logic             y;
   logic             err;
   logic             last_n;
   logic             we;

   weight_bank #(.WIDTH(WIDTH)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .wr_neuron (n),
      .wr_idx    (idx[2:0]),
      .wr_data   (w_next),
      .dp_sel    ({n, idx[2:0]}),
      .dp_data   (w_arr),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data)
   );

`ifdef BIAS_EN
   logic [WIDTH-1:0] bias [N_NEURON];

   assign is_bias = idx[3];
   assign w_cur   = is_bias ? bias[n] : w_arr;
   assign rd_bias = bias[rd_bias_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_NEURON; k++) bias[k] <= '0;
      end else if (state == ST_UPDATE && is_bias) begin
         bias[n] <= w_next;
      end
   end
`else
   assign is_bias = 1'b0;
   assign w_cur   = w_arr;
`endif

   // The bias step behaves as an input that is always 1.
   assign in_bit = is_bias | x_r[idx[2:0]];
   assign term   = in_bit ? w_cur : '0;
   assign y      = (acc >= ACC_W'(THRESH));
   assign err    = t_r[n] ^ y;
   assign last_n = (n == 3'd7);
   assign w_next = t_r[n] ? WIDTH'(sat_add(32'(w_cur), 32'(LR), W_MAX))
                          : WIDTH'(sat_sub(32'(w_cur), 32'(LR)));
   assign we     = (state == ST_UPDATE) && in_bit && !is_bias;

   assign train_ready = (state == ST_IDLE);
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         n       <= '0;
         idx     <= '0;
         acc     <= '0;
         x_r     <= '0;
         t_r     <= '0;
         pred    <= '0;
         err_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (train_valid) begin
                  x_r     <= x_in;
                  t_r     <= target_in;
                  pred    <= '0;
                  err_cnt <= '0;
                  n       <= '0;
                  idx     <= '0;
                  acc     <= '0;
                  state   <= ST_SUM;
               end
            end
            ST_SUM: begin
               acc <= acc + ACC_W'(term);
               if (idx == LAST_IDX) begin
                  idx   <= '0;
                  state <= ST_DECIDE;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            ST_DECIDE: begin
               pred[n] <= y;
               if (err) begin
                  err_cnt <= err_cnt + 4'd1;
                  idx     <= '0;
                  state   <= ST_UPDATE;
               end else if (last_n) begin
                  state <= ST_DONE;
               end else begin
                  n     <= n + 3'd1;
                  acc   <= '0;
                  idx   <= '0;
                  state <= ST_SUM;
               end
            end
            ST_UPDATE: begin
               // The last write step also hands over to the next neuron.
               if (idx != LAST_IDX) begin
                  idx <= idx + 4'd1;
               end else if (last_n) begin
                  state <= ST_DONE;
               end else begin
                  n     <= n + 3'd1;
                  acc   <= '0;
                  idx   <= '0;
                  state <= ST_SUM;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: a default instance and a WIDTH=2/THRESH=10 instance.
module tb_perceptron_trainer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       tv_a = 1'b0, tv_b = 1'b0;
   logic [7:0] x_a = '0, t_a = '0, x_b = '0, t_b = '0;
   logic       rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;
   logic [7:0] pred_a, pred_b;
   logic [3:0] ec_a, ec_b;
   logic [5:0] rd_sel_a = '0, rd_sel_b = '0;
   logic [7:0] rd_data_a;
   logic [1:0] rd_data_b;
`ifdef BIAS_EN
   logic [2:0] rbs_a = '0, rbs_b = '0;
   logic [7:0] rb_a;
   logic [1:0] rb_b;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   perceptron_trainer dut_a (
      .clk(clk), .rst_n(rst_n), .train_valid(tv_a), .train_ready(rdy_a),
      .x_in(x_a), .target_in(t_a), .busy(busy_a), .done(done_a),
      .pred(pred_a), .err_cnt(ec_a),
`ifdef BIAS_EN
      .rd_bias_sel(rbs_a), .rd_bias(rb_a),
`endif
      .rd_sel(rd_sel_a), .rd_data(rd_data_a)
   );

   perceptron_trainer #(.WIDTH(2), .THRESH(10), .LR(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .train_valid(tv_b), .train_ready(rdy_b),
      .x_in(x_b), .target_in(t_b), .busy(busy_b), .done(done_b),
      .pred(pred_b), .err_cnt(ec_b),
`ifdef BIAS_EN
      .rd_bias_sel(rbs_b), .rd_bias(rb_b),
`endif
      .rd_sel(rd_sel_b), .rd_data(rd_data_b)
   );

   // Counts weights differing from exp_w; byte i of exp_w is the expected value at index i for every neuron.
   task automatic scan_weights(input bit which, input logic [63:0] exp_w, output int bad);
      bad = 0;
      for (int nn = 0; nn < 8; nn++) begin
         for (int i = 0; i < 8; i++) begin
            if (which) rd_sel_b = {3'(nn), 3'(i)};
            else       rd_sel_a = {3'(nn), 3'(i)};
            #1;
            if (which) begin
               if ({6'b0, rd_data_b} !== exp_w[i*8 +: 8]) bad++;
            end else begin
               if (rd_data_a !== exp_w[i*8 +: 8]) bad++;
            end
         end
      end
   endtask

   // Offers one sample, returns cycles from accept to done (accept cycle = 1), or -1 on timeout.
   task automatic run_sample(input bit which, input logic [7:0] x, input logic [7:0] t, output int lat);
      logic d;
      @(negedge clk);
      if (which) begin x_b = x; t_b = t; tv_b = 1'b1; end
      else       begin x_a = x; t_a = t; tv_a = 1'b1; end
      @(posedge clk); #1;
      tv_a = 1'b0; tv_b = 1'b0;
      lat = 1;
      d = which ? done_b : done_a;
      while (!d && lat < 300) begin
         @(posedge clk); #1;
         lat++;
         d = which ? done_b : done_a;
      end
      if (!d) lat = -1;
      else begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      int bad;
      checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
      checks++; if (pred_a !== 8'h00) begin errors++; $display("FAIL reset_pred: got %h want 00", pred_a); end
      checks++; if (ec_a !== 4'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", ec_a); end
      scan_weights(1'b0, 64'h0, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL reset_weights: got %0d nonzero want 0", bad); end
   endtask

   task automatic test_reset_mid_update;
      int bad;
      @(negedge clk);
      x_a = 8'hFF; t_a = 8'hFF; tv_a = 1'b1;
      @(posedge clk); #1;
      tv_a = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rd_sel_a = 6'd0; #1;
      checks++; if (rd_data_a !== 8'd1) begin errors++; $display("FAIL midupd_w00: got %0d want 1", rd_data_a); end
      rst_n = 1'b0; #1;
      checks++; if (rdy_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL midupd_ctrl: got rdy=%b busy=%b done=%b want 1 0 0", rdy_a, busy_a, done_a); end
      checks++; if (pred_a !== 8'h00 || ec_a !== 4'd0) begin
         errors++; $display("FAIL midupd_status: got pred=%h err=%0d want 00 0", pred_a, ec_a); end
      scan_weights(1'b0, 64'h0, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL midupd_weights: got %0d nonzero want 0", bad); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_learn_from_zero;
      int lat, bad;
      run_sample(1'b0, 8'hFF, 8'hFF, lat);
      checks++; if (lat !== 137) begin errors++; $display("FAIL zero_latency: got %0d want 137", lat); end
      checks++; if (pred_a !== 8'h00) begin errors++; $display("FAIL zero_pred: got %h want 00", pred_a); end
      checks++; if (ec_a !== 4'd8) begin errors++; $display("FAIL zero_err_cnt: got %0d want 8", ec_a); end
      scan_weights(1'b0, 64'h01010101_01010101, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL zero_weights: got %0d wrong want 0", bad); end
   endtask

   task automatic test_repeat_converged;
      int lat, bad;
      run_sample(1'b0, 8'hFF, 8'hFF, lat);
      checks++; if (lat !== 73) begin errors++; $display("FAIL conv_latency: got %0d want 73", lat); end
      checks++; if (pred_a !== 8'hFF) begin errors++; $display("FAIL conv_pred: got %h want ff", pred_a); end
      checks++; if (ec_a !== 4'd0) begin errors++; $display("FAIL conv_err_cnt: got %0d want 0", ec_a); end
      scan_weights(1'b0, 64'h01010101_01010101, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL conv_weights: got %0d wrong want 0", bad); end
   endtask

   task automatic test_decrement_clamp;
      int lat, bad;
      run_sample(1'b0, 8'h03, 8'h00, lat);
      checks++; if (pred_a !== 8'hFF || ec_a !== 4'd8) begin
         errors++; $display("FAIL dec_pred: got pred=%h err=%0d want ff 8", pred_a, ec_a); end
      checks++; if (lat !== 137) begin errors++; $display("FAIL dec_latency: got %0d want 137", lat); end
      scan_weights(1'b0, 64'h01010101_01010000, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL dec_weights: got %0d wrong want 0", bad); end
      run_sample(1'b0, 8'h03, 8'h00, lat);
      checks++; if (pred_a !== 8'h00 || ec_a !== 4'd0 || lat !== 73) begin
         errors++; $display("FAIL dec_repeat: got pred=%h err=%0d lat=%0d want 00 0 73", pred_a, ec_a, lat); end
      // Weights 0,0,1,1 sum to 2: every neuron fires wrongly and idx 0/1 must stay clamped at 0.
      run_sample(1'b0, 8'h0F, 8'h00, lat);
      checks++; if (pred_a !== 8'hFF || ec_a !== 4'd8) begin
         errors++; $display("FAIL clamp_pred: got pred=%h err=%0d want ff 8", pred_a, ec_a); end
      scan_weights(1'b0, 64'h01010101_00000000, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_weights: got %0d wrong want 0", bad); end
   endtask

   task automatic test_saturate_small;
      int lat, bad;
      logic [1:0] want;
      for (int k = 1; k <= 5; k++) begin
         run_sample(1'b1, 8'h01, 8'hFF, lat);
         want = (k >= 3) ? 2'd3 : 2'(k);
         rd_sel_b = 6'd56; #1;
         checks++; if (rd_data_b !== want) begin
            errors++; $display("FAIL sat_w70_sample%0d: got %0d want %0d", k, rd_data_b, want); end
      end
      checks++; if (pred_b !== 8'h00 || ec_b !== 4'd8 || lat !== 137) begin
         errors++; $display("FAIL sat_status: got pred=%h err=%0d lat=%0d want 00 8 137", pred_b, ec_b, lat); end
      scan_weights(1'b1, 64'h00000000_00000003, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL sat_weights: got %0d wrong want 0", bad); end
   endtask

   task automatic test_back_to_back;
      int lat, bad;
      @(negedge clk);
      x_a = 8'h0F; t_a = 8'h00; tv_a = 1'b1;
      @(posedge clk); #1;
      x_a = 8'hFF; t_a = 8'hFF;
      lat = 1;
      while (!done_a && lat < 300) begin @(posedge clk); #1; lat++; end
      checks++; if (lat !== 73) begin errors++; $display("FAIL b2b_lat1: got %0d want 73", lat); end
      checks++; if (pred_a !== 8'h00 || ec_a !== 4'd0) begin
         errors++; $display("FAIL b2b_first: got pred=%h err=%0d want 00 0", pred_a, ec_a); end
      checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_done: got %b want 0", rdy_a); end
      @(posedge clk); #1;
      checks++; if (rdy_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: got rdy=%b busy=%b done=%b want 1 0 0", rdy_a, busy_a, done_a); end
      @(posedge clk); #1;
      checks++; if (busy_a !== 1'b1 || rdy_a !== 1'b0) begin
         errors++; $display("FAIL b2b_reaccept: got busy=%b rdy=%b want 1 0", busy_a, rdy_a); end
      x_a = 8'h00; t_a = 8'h00;
      lat = 1;
      while (!done_a && lat < 300) begin @(posedge clk); #1; lat++; end
      tv_a = 1'b0;
      checks++; if (pred_a !== 8'hFF || ec_a !== 4'd0 || lat !== 73) begin
         errors++; $display("FAIL b2b_second: got pred=%h err=%0d lat=%0d want ff 0 73", pred_a, ec_a, lat); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_accept: got busy=%b want 0", busy_a); end
      scan_weights(1'b0, 64'h01010101_00000000, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_weights: got %0d wrong want 0", bad); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      @(negedge clk); rst_n = 1'b1;
      test_reset_mid_update;
      test_learn_from_zero;
      test_repeat_converged;
      test_decrement_clamp;
      test_saturate_small;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
